// File: rtl/iqx4_and_time_deadlock_persist_monitor_if.sv
// Status/control bundle between the deadlock monitor and whoever drives and observes it.
interface iqx4_and_time_deadlock_persist_monitor_if #(
    parameter int unsigned NUM_AXIS = 3,
    parameter int unsigned NUM_INST = 1,
    parameter int unsigned CNT_W    = 16
);
    localparam int unsigned SRC_W = NUM_AXIS + NUM_INST;
    localparam int unsigned IDX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;

    logic                enable;
    logic                clear;
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_INST-1:0] inst_idle_sigs;
    logic [NUM_INST-1:0] inst_block_sigs;
    logic                block;
    logic [SRC_W-1:0]    block_cause;
    logic [IDX_W-1:0]    first_idx;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_cause, first_idx, stall_count
    );

    modport slave (
        input  enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_cause, first_idx, stall_count
    );
endinterface

// File: rtl/iqx4_and_time_deadlock_persist_monitor.sv
// Deadlock monitor: flags a stall only after it persists THRESH consecutive cycles,
// snapshots the offending sources and keeps a saturating count of stalled cycles.
module iqx4_and_time_deadlock_persist_monitor #(
    parameter int unsigned NUM_AXIS = 3,
    parameter int unsigned NUM_INST = 1,
    parameter int unsigned THRESH   = 16,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned STICKY   = 1
) (
    input logic clock,
    input logic reset,
    iqx4_and_time_deadlock_persist_monitor_if.slave mon
);
    localparam int unsigned SRC_W = NUM_AXIS + NUM_INST;
    localparam int unsigned IDX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_inc_c;
    logic [SRC_W-1:0] src_c;
    logic             stall_c;
    logic [IDX_W-1:0] src_idx_c;

    // Lowest set bit wins so the reported cause is deterministic when several sources stall.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [SRC_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = SRC_W - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // An idle instance is never treated as blocked.
    assign src_c      = {mon.inst_block_sigs & ~mon.inst_idle_sigs, mon.axis_block_sigs};
    assign stall_c    = |src_c;
    assign src_idx_c  = lowest_idx(src_c);
    assign pcnt_inc_c = pcnt + ONE_C;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pcnt            <= '0;
            mon.block       <= 1'b0;
            mon.block_cause <= '0;
            mon.first_idx   <= '0;
            mon.stall_count <= '0;
        end else if (mon.clear) begin
            state           <= IDLE;
            pcnt            <= '0;
            mon.block       <= 1'b0;
            mon.block_cause <= '0;
            mon.first_idx   <= '0;
            mon.stall_count <= '0;
        end else if (!mon.enable) begin
            // Disabled: drop qualification but keep the captured diagnostics.
            state     <= IDLE;
            pcnt      <= '0;
            mon.block <= 1'b0;
        end else begin
            if (stall_c && (mon.stall_count != {CNT_W{1'b1}})) begin
                mon.stall_count <= mon.stall_count + ONE_C;
            end

            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (stall_c) begin
                        pcnt <= ONE_C;
                        if (THRESH == 1) begin
                            state           <= BLOCKED;
                            mon.block       <= 1'b1;
                            mon.block_cause <= src_c;
                            mon.first_idx   <= src_idx_c;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end

                COUNT: begin
                    if (!stall_c) begin
                        state <= IDLE;
                        pcnt  <= '0;
                    end else begin
                        pcnt <= pcnt_inc_c;
                        if (pcnt_inc_c == THRESH_C) begin
                            state           <= BLOCKED;
                            mon.block       <= 1'b1;
                            mon.block_cause <= src_c;
                            mon.first_idx   <= src_idx_c;
                        end
                    end
                end

                BLOCKED: begin
                    mon.block <= 1'b1;
                    if ((STICKY == 0) && !stall_c) begin
                        state     <= IDLE;
                        pcnt      <= '0;
                        mon.block <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    pcnt      <= '0;
                    mon.block <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iqx4_and_time_deadlock_persist_monitor.sv
// Scoreboarded bench: three monitor configurations share one stimulus stream and each is
// compared every cycle against an independent run-length model.
module tb_iqx4_and_time_deadlock_persist_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    iqx4_and_time_deadlock_persist_monitor_if #(.NUM_AXIS(3), .NUM_INST(1), .CNT_W(16)) a_if ();
    iqx4_and_time_deadlock_persist_monitor_if #(.NUM_AXIS(3), .NUM_INST(1), .CNT_W(16)) b_if ();
    iqx4_and_time_deadlock_persist_monitor_if #(.NUM_AXIS(3), .NUM_INST(1), .CNT_W(4))  c_if ();

    // a: default sticky, b: legacy one-cycle non-sticky, c: narrow counter non-sticky
    iqx4_and_time_deadlock_persist_monitor #(
        .NUM_AXIS(3), .NUM_INST(1), .THRESH(16), .CNT_W(16), .STICKY(1)
    ) u_a (.clock(clock), .reset(reset), .mon(a_if.slave));

    iqx4_and_time_deadlock_persist_monitor #(
        .NUM_AXIS(3), .NUM_INST(1), .THRESH(1), .CNT_W(16), .STICKY(0)
    ) u_b (.clock(clock), .reset(reset), .mon(b_if.slave));

    iqx4_and_time_deadlock_persist_monitor #(
        .NUM_AXIS(3), .NUM_INST(1), .THRESH(4), .CNT_W(4), .STICKY(0)
    ) u_c (.clock(clock), .reset(reset), .mon(c_if.slave));

    typedef struct {
        int       run;
        bit       blk;
        bit [3:0] cause;
        int       idx;
        int       cnt;
    } model_t;

    typedef struct {
        logic        blk;
        logic [3:0]  cause;
        logic [1:0]  idx;
        logic [15:0] cnt;
    } exp_t;

    model_t ma, mb, mc;
    exp_t   q_a[$], q_b[$], q_c[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int low_bit(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Model in terms of consecutive stalled run length rather than a state machine.
    function automatic model_t mstep(input model_t m, input bit en, input bit clr,
                                     input bit [3:0] src, input int thresh,
                                     input bit sticky, input int cmax);
        model_t r;
        r = m;
        if (clr) begin
            r = '{default: 0};
        end else if (!en) begin
            r.run = 0;
            r.blk = 1'b0;
        end else if (src != 4'd0) begin
            if (r.cnt < cmax) r.cnt++;
            r.run++;
            if (!r.blk && r.run == thresh) begin
                r.blk   = 1'b1;
                r.cause = src;
                r.idx   = low_bit(src);
            end
        end else begin
            r.run = 0;
            if (!sticky) r.blk = 1'b0;
        end
        return r;
    endfunction

    function automatic exp_t to_exp(input model_t m);
        exp_t e;
        e.blk   = m.blk;
        e.cause = m.cause;
        e.idx   = 2'(m.idx);
        e.cnt   = 16'(m.cnt);
        return e;
    endfunction

    task automatic drive(input bit en, input bit clr, input logic [2:0] ab,
                         input logic ii, input logic ib);
        a_if.enable = en; a_if.clear = clr; a_if.axis_block_sigs = ab;
        a_if.inst_idle_sigs = ii; a_if.inst_block_sigs = ib;
        b_if.enable = en; b_if.clear = clr; b_if.axis_block_sigs = ab;
        b_if.inst_idle_sigs = ii; b_if.inst_block_sigs = ib;
        c_if.enable = en; c_if.clear = clr; c_if.axis_block_sigs = ab;
        c_if.inst_idle_sigs = ii; c_if.inst_block_sigs = ib;
    endtask

    task automatic step(input bit en, input bit clr, input logic [2:0] ab,
                        input logic ii, input logic ib);
        bit [3:0] src;
        exp_t     e;
        @(negedge clock);
        drive(en, clr, ab, ii, ib);
        src = {ib & ~ii, ab};
        ma = mstep(ma, en, clr, src, 16, 1'b1, 65535);
        mb = mstep(mb, en, clr, src, 1, 1'b0, 65535);
        mc = mstep(mc, en, clr, src, 4, 1'b0, 15);
        q_a.push_back(to_exp(ma));
        q_b.push_back(to_exp(mb));
        q_c.push_back(to_exp(mc));
        @(posedge clock);
        #1;
        e = q_a.pop_front();
        check("a_block", a_if.block, e.blk);
        check("a_cause", a_if.block_cause, e.cause);
        check("a_idx", a_if.first_idx, e.idx);
        check("a_count", a_if.stall_count, e.cnt);
        e = q_b.pop_front();
        check("b_block", b_if.block, e.blk);
        check("b_cause", b_if.block_cause, e.cause);
        check("b_idx", b_if.first_idx, e.idx);
        check("b_count", b_if.stall_count, e.cnt);
        e = q_c.pop_front();
        check("c_block", c_if.block, e.blk);
        check("c_cause", c_if.block_cause, e.cause);
        check("c_idx", c_if.first_idx, e.idx);
        check("c_count", c_if.stall_count, e.cnt);
    endtask

    task automatic stall_n(input int n, input logic [2:0] ab);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, ab, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_block"}, a_if.block, 0);
        check({tag, "_a_cause"}, a_if.block_cause, 0);
        check({tag, "_a_idx"}, a_if.first_idx, 0);
        check({tag, "_a_count"}, a_if.stall_count, 0);
        check({tag, "_b_block"}, b_if.block, 0);
        check({tag, "_b_count"}, b_if.stall_count, 0);
        check({tag, "_c_block"}, c_if.block, 0);
        check({tag, "_c_count"}, c_if.stall_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        mc = '{default: 0};
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // 15-cycle stall must not qualify
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(15, 3'b010);
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        check("t1_block", a_if.block, 0);
        check("t1_count", a_if.stall_count, 15);

        // 16-cycle stall qualifies and sticks until clear
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(15, 3'b010);
        check("t2_pre", a_if.block, 0);
        stall_n(1, 3'b010);
        check("t2_block", a_if.block, 1);
        check("t2_cause", a_if.block_cause, 4'b0010);
        check("t2_idx", a_if.first_idx, 1);
        repeat (3) step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        check("t2_sticky", a_if.block, 1);
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        check("t2_clr_block", a_if.block, 0);
        check("t2_clr_cause", a_if.block_cause, 0);
        check("t2_clr_count", a_if.stall_count, 0);

        // idle instance is never blocked; then it becomes blocked
        repeat (40) step(1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        check("t3_idle_block", a_if.block, 0);
        check("t3_idle_count", a_if.stall_count, 0);
        repeat (16) step(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
        check("t3_block", a_if.block, 1);
        check("t3_cause", a_if.block_cause, 4'b1000);
        check("t3_idx", a_if.first_idx, 3);
        repeat (2) step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);

        // legacy one-cycle behaviour on b
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(1, 3'b101);
        check("t4_b_first", b_if.block, 1);
        check("t4_b_idx", b_if.first_idx, 0);
        stall_n(2, 3'b101);
        check("t4_b_hold", b_if.block, 1);
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        check("t4_b_drop", b_if.block, 0);
        check("t4_b_cause_kept", b_if.block_cause, 4'b0101);

        // glitch restarts qualification
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(10, 3'b001);
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        stall_n(15, 3'b001);
        check("t5_glitch_pre", a_if.block, 0);
        stall_n(1, 3'b001);
        check("t5_glitch_blk", a_if.block, 1);

        // clear on the qualifying edge wins, then a fresh 16 cycles are needed
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(15, 3'b100);
        step(1'b1, 1'b1, 3'b100, 1'b0, 1'b0);
        check("t5_clr_win", a_if.block, 0);
        stall_n(15, 3'b100);
        check("t5_requal_pre", a_if.block, 0);
        stall_n(1, 3'b100);
        check("t5_requal", a_if.block, 1);
        check("t5_requal_idx", a_if.first_idx, 2);

        // enable low drops block but keeps diagnostics
        repeat (3) step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
        check("t6_en_block", a_if.block, 0);
        check("t6_en_cause", a_if.block_cause, 4'b0100);
        check("t6_en_count", a_if.stall_count, 16);

        // narrow counter saturates
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(20, 3'b011);
        check("t7_sat", c_if.stall_count, 15);

        // randomised bursts
        for (int b = 0; b < 40; b++) begin
            logic [2:0] pat;
            logic       ii, ib;
            int         len;
            pat = 3'($urandom_range(0, 7));
            ii  = 1'($urandom_range(0, 1));
            ib  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++)
                step($urandom_range(0, 15) != 0, $urandom_range(0, 40) == 0, pat, ii, ib);
        end

        // asynchronous reset mid-stall
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        stall_n(18, 3'b010);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        ma = '{default: 0};
        mb = '{default: 0};
        mc = '{default: 0};
        @(negedge clock);
        reset = 1'b0;
        stall_n(15, 3'b010);
        check("t8_fresh_pre", a_if.block, 0);
        stall_n(1, 3'b010);
        check("t8_fresh_blk", a_if.block, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
